// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers ALU results, resolves branches from the zero
// flag, runs load/store accesses over a req/ack handshake and feeds write-back/forwarding.
module ex_mem_stage #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [DSIZE-1:0] ex_alu_out,
   input  logic             ex_zero,
   input  logic [DSIZE-1:0] ex_store_data,
   input  logic [ASIZE-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   input  logic             ex_branch,
   input  logic             flush,
   output logic             stall,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [DSIZE-1:0] dmem_addr,
   output logic [DSIZE-1:0] dmem_wdata,
   input  logic [DSIZE-1:0] dmem_rdata,
   input  logic             dmem_ack,
   output logic             branch_taken,
   output logic             wb_valid,
   output logic             wb_reg_write,
   output logic [ASIZE-1:0] wb_rd,
   output logic [DSIZE-1:0] wb_data,
   output logic             fwd_valid,
   output logic [ASIZE-1:0] fwd_rd,
   output logic [DSIZE-1:0] fwd_data
);

   typedef enum logic {IDLE, MEM_WAIT} state_t;

   state_t           state_q, state_d;
   logic             wb_valid_q, wb_valid_d;
   logic             wb_reg_write_q, wb_reg_write_d;
   logic [ASIZE-1:0] wb_rd_q, wb_rd_d;
   logic [DSIZE-1:0] wb_data_q, wb_data_d;
   logic             branch_taken_q, branch_taken_d;
   logic             dmem_we_q, dmem_we_d;
   logic [DSIZE-1:0] dmem_addr_q, dmem_addr_d;
   logic [DSIZE-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [ASIZE-1:0] cap_rd_q, cap_rd_d;
   logic             cap_reg_write_q, cap_reg_write_d;
   logic             accepted;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         wb_valid_q      <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_rd_q         <= '0;
         wb_data_q       <= '0;
         branch_taken_q  <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= '0;
         dmem_wdata_q    <= '0;
         cap_rd_q        <= '0;
         cap_reg_write_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         wb_valid_q      <= wb_valid_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_rd_q         <= wb_rd_d;
         wb_data_q       <= wb_data_d;
         branch_taken_q  <= branch_taken_d;
         dmem_we_q       <= dmem_we_d;
         dmem_addr_q     <= dmem_addr_d;
         dmem_wdata_q    <= dmem_wdata_d;
         cap_rd_q        <= cap_rd_d;
         cap_reg_write_q <= cap_reg_write_d;
      end
   end

   assign accepted = ex_valid & ~flush;

   always_comb begin
      state_d         = state_q;
      wb_valid_d      = 1'b0;
      wb_reg_write_d  = wb_reg_write_q;
      wb_rd_d         = wb_rd_q;
      wb_data_d       = wb_data_q;
      branch_taken_d  = 1'b0;
      dmem_we_d       = dmem_we_q;
      dmem_addr_d     = dmem_addr_q;
      dmem_wdata_d    = dmem_wdata_q;
      cap_rd_d        = cap_rd_q;
      cap_reg_write_d = cap_reg_write_q;
      case (state_q)
         IDLE: begin
            // Store wins over load when both are (illegally) asserted.
            if (accepted && (ex_mem_write || ex_mem_read)) begin
               state_d         = MEM_WAIT;
               dmem_we_d       = ex_mem_write;
               dmem_addr_d     = ex_alu_out;
               dmem_wdata_d    = ex_store_data;
               cap_rd_d        = ex_rd;
               cap_reg_write_d = ex_reg_write;
            end else if (accepted) begin
               wb_valid_d     = 1'b1;
               wb_rd_d        = ex_rd;
               wb_data_d      = ex_alu_out;
               wb_reg_write_d = ex_branch ? 1'b0 : ex_reg_write;
               branch_taken_d = ex_branch & ex_zero;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = cap_rd_q;
               if (dmem_we_q) begin
                  wb_reg_write_d = 1'b0;
               end else begin
                  wb_reg_write_d = cap_reg_write_q;
                  wb_data_d      = dmem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The request is a pure decode of the state so async reset drops it at once.
   always_comb begin
      stall        = (state_q == MEM_WAIT);
      dmem_req     = (state_q == MEM_WAIT);
      dmem_we      = dmem_we_q;
      dmem_addr    = dmem_addr_q;
      dmem_wdata   = dmem_wdata_q;
      branch_taken = branch_taken_q;
      wb_valid     = wb_valid_q;
      wb_reg_write = wb_reg_write_q;
      wb_rd        = wb_rd_q;
      wb_data      = wb_data_q;
      fwd_valid    = wb_valid_q & wb_reg_write_q & (state_q == IDLE);
      fwd_rd       = wb_rd_q;
      fwd_data     = wb_data_q;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a scoreboard queue holds the expected
// write-back bundles, popped by a monitor whenever wb_valid is seen.
module tb_ex_mem_stage;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [15:0] ex_alu_out;
   logic        ex_zero;
   logic [15:0] ex_store_data;
   logic [3:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_branch;
   logic        flush;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ack;
   logic        branch_taken;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        fwd_valid;
   logic [3:0]  fwd_rd;
   logic [15:0] fwd_data;

   typedef struct {
      logic        rw;
      logic [3:0]  rd;
      logic [15:0] data;
      logic        bt;
      logic        chkData;
   } exp_t;

   exp_t sbQ[$];
   int   assertCount = 0;
   int   failCount   = 0;

   ex_mem_stage #(.DSIZE(16), .ASIZE(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_zero(ex_zero),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .flush(flush), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .branch_taken(branch_taken),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction for a single edge, then returns the inputs to a bubble.
   task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic z,
                                input logic [15:0] sd, input logic [3:0] rd, input logic rw,
                                input logic mr, input logic mw, input logic br, input logic fl);
      ex_valid = v; ex_alu_out = alu; ex_zero = z; ex_store_data = sd; ex_rd = rd;
      ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_branch = br; flush = fl;
      tick();
      ex_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic pushExp(input logic rw, input logic [3:0] rd, input logic [15:0] data,
                          input logic bt, input logic chk);
      exp_t e;
      e.rw = rw; e.rd = rd; e.data = data; e.bt = bt; e.chkData = chk;
      sbQ.push_back(e);
   endtask

   // Write-back monitor: every valid bundle must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (wb_valid) begin
            if (sbQ.size() == 0) begin
               checkOutput("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
               e = sbQ.pop_front();
               checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
               checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
               checkOutput("branch_taken", 32'(branch_taken), 32'(e.bt));
               checkOutput("fwd_valid", 32'(fwd_valid), 32'(e.rw));
               checkOutput("fwd_rd", 32'(fwd_rd), 32'(e.rd));
               if (e.chkData) begin
                  checkOutput("wb_data", 32'(wb_data), 32'(e.data));
                  checkOutput("fwd_data", 32'(fwd_data), 32'(e.data));
               end
            end
         end else begin
            checkOutput("bt_idle", 32'(branch_taken), 32'd0);
            checkOutput("fwd_idle", 32'(fwd_valid), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      ex_valid = 0; ex_alu_out = 0; ex_zero = 0; ex_store_data = 0; ex_rd = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_branch = 0; flush = 0;
      dmem_rdata = 0; dmem_ack = 0;
      #12;
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_bt", 32'(branch_taken), 32'd0);
      checkOutput("rst_fwd", 32'(fwd_valid), 32'd0);
      rst = 1'b1;
      tick();

      $display("[TB] ALU op");
      pushExp(1'b1, 4'd3, 16'h0042, 1'b0, 1'b1);
      checkOutput("alu_stall_pre", 32'(stall), 32'd0);
      applyStimulus(1, 16'h0042, 0, 16'h0, 4'd3, 1, 0, 0, 0, 0);
      checkOutput("alu_stall_post", 32'(stall), 32'd0);
      checkOutput("alu_wb_valid", 32'(wb_valid), 32'd1);
      tick();

      $display("[TB] branches");
      pushExp(1'b0, 4'd4, 16'h0, 1'b1, 1'b0);
      applyStimulus(1, 16'h0000, 1, 16'h0, 4'd4, 1, 0, 0, 1, 0);
      pushExp(1'b0, 4'd6, 16'h0, 1'b0, 1'b0);
      applyStimulus(1, 16'h0007, 0, 16'h0, 4'd6, 1, 0, 0, 1, 0);
      tick();

      $display("[TB] load with 3-cycle ack");
      pushExp(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1);
      applyStimulus(1, 16'h0010, 0, 16'h0, 4'd5, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("ld_stall", 32'(stall), 32'd1);
         checkOutput("ld_req", 32'(dmem_req), 32'd1);
         checkOutput("ld_we", 32'(dmem_we), 32'd0);
         checkOutput("ld_addr", 32'(dmem_addr), 32'h0010);
         checkOutput("ld_wb_valid", 32'(wb_valid), 32'd0);
         if (i == 2) begin
            dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
         end
         tick();
      end
      dmem_ack = 1'b0; dmem_rdata = 16'h0;
      checkOutput("ld_stall_done", 32'(stall), 32'd0);
      checkOutput("ld_req_done", 32'(dmem_req), 32'd0);
      checkOutput("ld_wb_data", 32'(wb_data), 32'hBEEF);
      tick();

      $display("[TB] store with flush during wait");
      pushExp(1'b0, 4'd7, 16'h0, 1'b0, 1'b0);
      applyStimulus(1, 16'h0020, 0, 16'h1234, 4'd7, 1, 0, 1, 0, 0);
      checkOutput("st_req", 32'(dmem_req), 32'd1);
      checkOutput("st_we", 32'(dmem_we), 32'd1);
      checkOutput("st_wdata", 32'(dmem_wdata), 32'h1234);
      checkOutput("st_addr", 32'(dmem_addr), 32'h0020);
      ex_valid = 1; ex_alu_out = 16'h0055; ex_zero = 0; ex_store_data = 0; ex_rd = 4'd2;
      ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0; ex_branch = 0;
      flush = 1'b1; dmem_ack = 1'b1;
      tick();
      flush = 1'b0; dmem_ack = 1'b0;
      checkOutput("st_stall_done", 32'(stall), 32'd0);
      pushExp(1'b1, 4'd2, 16'h0055, 1'b0, 1'b1);
      tick();
      ex_valid = 1'b0;
      tick();

      $display("[TB] flushed instruction and stray ack");
      dmem_ack = 1'b1;
      applyStimulus(1, 16'h0030, 1, 16'h0, 4'd8, 1, 1, 0, 0, 1);
      dmem_ack = 1'b0;
      checkOutput("fl_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("fl_bt", 32'(branch_taken), 32'd0);
      checkOutput("fl_req", 32'(dmem_req), 32'd0);
      checkOutput("fl_stall", 32'(stall), 32'd0);
      tick();

      $display("[TB] reset during wait");
      applyStimulus(1, 16'h0040, 0, 16'h0, 4'd9, 1, 1, 0, 0, 0);
      checkOutput("rw_req_before", 32'(dmem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("rw_req_async", 32'(dmem_req), 32'd0);
      checkOutput("rw_stall_async", 32'(stall), 32'd0);
      checkOutput("rw_wb_valid_async", 32'(wb_valid), 32'd0);
      #3 rst = 1'b1;
      tick();
      checkOutput("rw_stall_after", 32'(stall), 32'd0);
      checkOutput("rw_req_after", 32'(dmem_req), 32'd0);
      pushExp(1'b1, 4'd1, 16'hA5A5, 1'b0, 1'b1);
      applyStimulus(1, 16'hA5A5, 0, 16'h0, 4'd1, 1, 0, 0, 0, 0);
      tick();
      tick();

      checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
